prbs17_checker: RTL and testbench
=================================

// Module: prbs17_checker
// PURPOSE
//  Serial receive-side checker for the 17-bit LFSR pattern (x^17 + x^14 + 1,
//    feedback = S[16]^S[13], shift left, new bit enters at S[0]).
//  Self-synchronises to the incoming bit stream, declares lock, then counts bit errors.
//  Declares loss of sync when the error density exceeds a threshold.
//  Sits at the far end of a link driven by the 17-bit LFSR generator, for BER/link test.
// PARAMETERS
//  LOCK_CNT    34   consecutive predicted-bit matches in HUNT required to lock (1..255)
//  WIN_LEN     128  LOCKED-mode error window, in valid bits (2..65535)
//  ERR_THRESH  8    errors within one window that force loss of sync (1..WIN_LEN)
//  CNT_W       16   width of err_count
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  din        in   1      received PRBS bit (generator's new S[0] per shift)
//  din_valid  in   1      din is sampled only when high; gaps allowed at any point
//  clr_cnt    in   1      synchronous clear of err_count
//  locked     out  1      registered, high while in LOCKED
//  err_pulse  out  1      one-cycle pulse per counted error (LOCKED only)
//  sync_lost  out  1      one-cycle pulse on the LOCKED->FILL transition
//  err_count  out  CNT_W  saturating error total since reset/clr_cnt
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): S=0, state=FILL, fill/match/window counters=0,
//    locked=0, err_pulse=0, sync_lost=0, err_count=0. Reset mid-lock does the same.
//  All state and outputs update only on cycles with din_valid=1, except:
//    err_pulse/sync_lost deassert the next cycle; clr_cnt acts on any cycle.
//  exp = S[16]^S[13]; mis = din ^ exp. Outputs registered: 1-cycle latency from sample.
//  FILL: S <= {S[15:0],din}; fill_cnt++. After the 17th valid bit -> HUNT, match_cnt=0.
//  HUNT: S <= {S[15:0],din} (self-sync, always loads received bit).
//    - S==0: match_cnt held at 0. All-zero input must never lock.
//    - mis=0: match_cnt++. mis=1: match_cnt=0.
//    - On the valid bit where match_cnt becomes LOCK_CNT -> LOCKED, locked=1.
//    - win_cnt=0, win_err=0.
//  LOCKED (flywheel): S <= {S[15:0],exp}. Received bit is never loaded,
//    so one flipped bit yields exactly one error.
//    - mis=1: err_pulse=1; err_count++ (holds at 2^CNT_W-1); win_err++.
//    - win_cnt++ per valid bit. On reaching WIN_LEN: win_cnt=0, win_err=0
//      (an error on that same bit counts into the new window, i.e. win_err=1).
//    - win_err reaching ERR_THRESH -> FILL: fill_cnt=0, locked=0, sync_lost=1.
//      That error is still counted in err_count.
//  clr_cnt=1: err_count <= 0. If the same valid bit is also an error, err_count <= 1.
//    clr_cnt does not affect state, lock, or the window.
//  din_valid=0: S, counters and state hold. Gaps of any length are transparent.
// TESTING
//  1 Generator stream, seed 17'b101011, continuous valid -> locked rises on the edge
//    sampling valid bit 51 (17+34); err_count=0 after 10000 bits.
//  2 Locked, flip one bit at index 500 -> single err_pulse, err_count=1, locked stays 1,
//    no further errors.
//  3 Locked, flip 8 bits within 100 bits -> sync_lost pulse on 8th error, locked=0,
//    err_count=8; clean stream thereafter relocks 51 valid bits later.
//    7 flips per 128-bit window repeated x10 -> stays locked, err_count=70.
//  4 din=0 constant (valid=1) for 5000 bits -> locked never asserts.
//    Random data -> no lock (match_cnt never reaches 34).
//  5 Case 1 with din_valid toggling 1/0/0 -> identical lock bit-index and err_count
//    as continuous case.
//  6 err_count preset near full (CNT_W=4 build) -> holds at 15.
//    clr_cnt coincident with error -> 1. rst_n low mid-LOCKED -> all outputs 0 next edge.

Source files
------------

// File: rtl/prbs17_checker.sv
// Receive-side checker for the x^17 + x^14 + 1 PRBS: self-synchronises, locks,
// then flywheels the local LFSR and counts bit errors with a windowed loss-of-sync test.
module prbs17_checker #(
    parameter int LOCK_CNT   = 34,
    parameter int WIN_LEN    = 128,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_lost,
    output logic [CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {FILL, HUNT, LOCKED} state_t;

    localparam logic [7:0]       LOCK_V   = 8'(LOCK_CNT);
    localparam logic [15:0]      WIN_V    = 16'(WIN_LEN);
    localparam logic [15:0]      THRESH_V = 16'(ERR_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic [16:0]      lfsr, lfsr_nxt;
    logic [4:0]       fill_cnt, fill_nxt;
    logic [7:0]       match_cnt, match_nxt;
    logic [15:0]      win_cnt, win_nxt;
    logic [15:0]      win_err, win_err_nxt;
    logic             locked_nxt, err_pulse_nxt, sync_lost_nxt;
    logic [CNT_W-1:0] err_count_nxt;
    logic             exp_bit, mis, count_err;

    assign exp_bit = lfsr[16] ^ lfsr[13];
    assign mis     = din ^ exp_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            lfsr      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            sync_lost <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            win_cnt   <= win_nxt;
            win_err   <= win_err_nxt;
            locked    <= locked_nxt;
            err_pulse <= err_pulse_nxt;
            sync_lost <= sync_lost_nxt;
            err_count <= err_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        lfsr_nxt      = lfsr;
        fill_nxt      = fill_cnt;
        match_nxt     = match_cnt;
        win_nxt       = win_cnt;
        win_err_nxt   = win_err;
        locked_nxt    = locked;
        err_pulse_nxt = 1'b0;
        sync_lost_nxt = 1'b0;
        count_err     = 1'b0;

        if (din_valid) begin
            case (state)
                FILL: begin
                    lfsr_nxt = {lfsr[15:0], din};
                    fill_nxt = fill_cnt + 5'd1;
                    if (fill_cnt == 5'd16) begin
                        state_nxt = HUNT;
                        match_nxt = '0;
                    end
                end
                HUNT: begin
                    lfsr_nxt    = {lfsr[15:0], din};
                    win_nxt     = '0;
                    win_err_nxt = '0;
                    // An all-zero register predicts zeros forever, so it must never earn matches.
                    if (lfsr == 17'd0 || mis) begin
                        match_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + 8'd1;
                        if (match_cnt + 8'd1 == LOCK_V) begin
                            state_nxt  = LOCKED;
                            locked_nxt = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    lfsr_nxt      = {lfsr[15:0], exp_bit};
                    count_err     = mis;
                    err_pulse_nxt = mis;
                    if (win_cnt + 16'd1 == WIN_V) begin
                        win_nxt     = '0;
                        win_err_nxt = {15'd0, mis};
                    end else begin
                        win_nxt     = win_cnt + 16'd1;
                        win_err_nxt = win_err + {15'd0, mis};
                    end
                    if (mis && win_err_nxt == THRESH_V) begin
                        state_nxt     = FILL;
                        fill_nxt      = '0;
                        locked_nxt    = 1'b0;
                        sync_lost_nxt = 1'b1;
                    end
                end
                default: state_nxt = FILL;
            endcase
        end

        // A clear that coincides with an error leaves that error counted.
        err_count_nxt = err_count;
        if (clr_cnt) begin
            err_count_nxt = {{(CNT_W-1){1'b0}}, count_err};
        end else if (count_err && err_count != CNT_MAX) begin
            err_count_nxt = err_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_prbs17_checker.sv
// Bench for prbs17_checker: a bit-history receiver model checked every cycle,
// plus literal expectations for lock timing, error counting and loss of sync.
`timescale 1ns/1ps
module tb_prbs17_checker;
    localparam int          LOCK_CNT   = 34;
    localparam int          WIN_LEN    = 128;
    localparam int          ERR_THRESH = 8;
    localparam logic [16:0] SEED       = 17'b101011;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        din       = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr_cnt   = 1'b0;
    logic        locked, err_pulse, sync_lost;
    logic [15:0] err_count;
    logic        locked4, err_pulse4, sync_lost4;
    logic [3:0]  err_count4;

    int cmp_count  = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    prbs17_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .ERR_THRESH(ERR_THRESH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .sync_lost(sync_lost), .err_count(err_count)
    );

    prbs17_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .ERR_THRESH(ERR_THRESH), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .sync_lost(sync_lost4), .err_count(err_count4)
    );

    // Receiver model: remembers the last 17 reference bits; the next bit is bit[-17] ^ bit[-14].
    typedef enum int {M_FILL, M_HUNT, M_LOCK} mmode_t;
    mmode_t m_mode;
    bit     hist[$];
    int     m_fill, m_match, m_lockpos, m_cur_win, m_werr, m_cnt, m_cnt4;
    bit     m_locked, m_pulse, m_lost;
    bit     m_ready = 1'b0;

    logic [16:0] gen;
    bit          flip_map [0:1999];
    int          lock_idx, lost_idx, pulse_cnt;

    function automatic bit predictBit();
        return hist[hist.size()-17] ^ hist[hist.size()-14];
    endfunction

    function automatic bit lastAllZero();
        for (int k = hist.size() - 17; k < hist.size(); k++)
            if (hist[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pushHist(input bit b);
        hist.push_back(b);
        if (hist.size() > 17) void'(hist.pop_front());
    endtask

    task automatic modelStep(input logic r, input logic v, input logic d, input logic c);
        bit err, pred, zero;
        err = 1'b0; m_pulse = 1'b0; m_lost = 1'b0;
        if (r !== 1'b1) begin
            m_mode = M_FILL; hist.delete();
            m_fill = 0; m_match = 0; m_lockpos = 0; m_cur_win = 0; m_werr = 0;
            m_locked = 1'b0; m_cnt = 0; m_cnt4 = 0; m_ready = 1'b1;
        end else begin
            if (v === 1'b1) begin
                case (m_mode)
                    M_FILL: begin
                        pushHist(d);
                        m_fill++;
                        if (m_fill == 17) begin m_mode = M_HUNT; m_match = 0; end
                    end
                    M_HUNT: begin
                        pred = predictBit();
                        zero = lastAllZero();
                        pushHist(d);
                        if (zero || d !== pred) m_match = 0; else m_match++;
                        if (m_match == LOCK_CNT) begin
                            m_mode = M_LOCK; m_locked = 1'b1;
                            m_lockpos = 0; m_cur_win = 0; m_werr = 0;
                        end
                    end
                    M_LOCK: begin
                        pred = predictBit();
                        err  = (d !== pred);
                        pushHist(pred);
                        m_lockpos++;
                        // Window k holds locked bits whose ordinal / WIN_LEN == k.
                        if (m_lockpos / WIN_LEN != m_cur_win) begin
                            m_cur_win = m_lockpos / WIN_LEN; m_werr = 0;
                        end
                        if (err) begin m_werr++; m_pulse = 1'b1; end
                        if (err && m_werr == ERR_THRESH) begin
                            m_mode = M_FILL; m_fill = 0; m_locked = 1'b0; m_lost = 1'b1;
                        end
                    end
                endcase
            end
            if (c === 1'b1) begin
                m_cnt = int'(err); m_cnt4 = int'(err);
            end else if (err) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic d, input logic v, input logic c, input logic r);
        @(negedge clk);
        din = d; din_valid = v; clr_cnt = c; rst_n = r;
        @(posedge clk);
        #1;
    endtask

    task automatic nextGen(output logic b);
        b   = gen[16] ^ gen[13];
        gen = {gen[15:0], b};
    endtask

    task automatic clearFlips();
        for (int k = 0; k < 2000; k++) flip_map[k] = 1'b0;
    endtask

    task automatic doReset(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic runGen(input int n, input bit gaps);
        logic b, prev;
        lock_idx = -1; lost_idx = -1; pulse_cnt = 0;
        prev = locked;
        for (int i = 1; i <= n; i++) begin
            nextGen(b);
            applyStimulus(b ^ ((i < 2000) ? flip_map[i] : 1'b0), 1'b1, 1'b0, 1'b1);
            if (err_pulse === 1'b1) pulse_cnt++;
            if (sync_lost === 1'b1 && lost_idx < 0) lost_idx = i;
            if (locked === 1'b1 && prev !== 1'b1 && lock_idx < 0) lock_idx = i;
            prev = locked;
            if (gaps) repeat (2) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic randomPhase(input int n);
        logic b, v, f, c;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) nextGen(b); else b = 1'($urandom_range(0, 1));
            f = v && ($urandom_range(0, 19) == 0);
            c = ($urandom_range(0, 199) == 0);
            applyStimulus(b ^ f, v, c, 1'b1);
        end
    endtask

    task automatic compareLoop();
        forever begin
            @(posedge clk);
            modelStep(rst_n, din_valid, din, clr_cnt);
            #1;
            if (m_ready) begin
                checkOutput("locked", 64'(locked), 64'(m_locked));
                checkOutput("err_pulse", 64'(err_pulse), 64'(m_pulse));
                checkOutput("sync_lost", 64'(sync_lost), 64'(m_lost));
                checkOutput("err_count", 64'(err_count), 64'(m_cnt));
                checkOutput("locked_w4", 64'(locked4), 64'(m_locked));
                checkOutput("err_count_w4", 64'(err_count4), 64'(m_cnt4));
            end
        end
    endtask

    task automatic mainSequence();
        logic b;
        bit   ever;
        doReset(2);
        checkOutput("reset_locked", 64'(locked), 64'd0);
        checkOutput("reset_err_count", 64'(err_count), 64'd0);

        $display("[TB] clean generator stream, continuous valid");
        gen = SEED; clearFlips();
        runGen(10000, 1'b0);
        checkOutput("lock_index", 64'(lock_idx), 64'd51);
        checkOutput("clean_err_count", 64'(err_count), 64'd0);

        $display("[TB] single flipped bit while locked");
        clearFlips(); flip_map[500] = 1'b1;
        runGen(1000, 1'b0);
        checkOutput("single_pulses", 64'(pulse_cnt), 64'd1);
        checkOutput("single_err_count", 64'(err_count), 64'd1);
        checkOutput("single_locked", 64'(locked), 64'd1);
        checkOutput("single_no_loss", 64'(lost_idx), 64'hFFFF_FFFF_FFFF_FFFF);

        nextGen(b);
        applyStimulus(~b, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_with_error", 64'(err_count), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_idle", 64'(err_count), 64'd0);
        checkOutput("clr_keeps_lock", 64'(locked), 64'd1);

        $display("[TB] burst of errors forces loss of sync");
        doReset(2); clearFlips();
        runGen(51, 1'b0);
        checkOutput("relock_index", 64'(lock_idx), 64'd51);
        for (int k = 1; k <= 8; k++) flip_map[2*k] = 1'b1;
        runGen(200, 1'b0);
        checkOutput("loss_index", 64'(lost_idx), 64'd16);
        checkOutput("loss_relock_index", 64'(lock_idx), 64'd67);
        checkOutput("loss_err_count", 64'(err_count), 64'd8);
        checkOutput("loss_pulses", 64'(pulse_cnt), 64'd8);

        $display("[TB] seven errors per window, ten windows");
        doReset(2); clearFlips();
        runGen(51, 1'b0);
        for (int w = 0; w < 10; w++)
            for (int k = 1; k <= 7; k++) flip_map[w*WIN_LEN + k*10] = 1'b1;
        runGen(1280, 1'b0);
        checkOutput("window_locked", 64'(locked), 64'd1);
        checkOutput("window_no_loss", 64'(lost_idx), 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("window_err_count", 64'(err_count), 64'd70);
        checkOutput("window_err_count_w4", 64'(err_count4), 64'd15);

        nextGen(b);
        applyStimulus(~b, 1'b1, 1'b0, 1'b0);
        checkOutput("midlock_reset_locked", 64'(locked), 64'd0);
        checkOutput("midlock_reset_pulse", 64'(err_pulse), 64'd0);
        checkOutput("midlock_reset_lost", 64'(sync_lost), 64'd0);
        checkOutput("midlock_reset_count", 64'(err_count), 64'd0);

        $display("[TB] all-zero and random input");
        ever = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            if (locked !== 1'b0) ever = 1'b1;
        end
        checkOutput("zeros_never_lock", 64'(ever), 64'd0);
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
            if (locked !== 1'b0) ever = 1'b1;
        end
        checkOutput("random_never_lock", 64'(ever), 64'd0);

        $display("[TB] valid pattern 1/0/0");
        doReset(2); gen = SEED; clearFlips();
        runGen(2000, 1'b1);
        checkOutput("gap_lock_index", 64'(lock_idx), 64'd51);
        checkOutput("gap_err_count", 64'(err_count), 64'd0);
        checkOutput("gap_locked", 64'(locked), 64'd1);

        $display("[TB] randomized errors, gaps and clears");
        randomPhase(3000);
    endtask

    initial begin
        fork
            compareLoop();
            mainSequence();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule
